// File: rtl/truco_bet_ctrl.sv
// Bet-negotiation controller for one Truco hand: tracks the 1/3/6/9/12 value ladder,
// enforces turn order between the two players and flags folds and illegal requests.
module truco_bet_ctrl (
   input  logic       clk,
   input  logic       clr,
   input  logic       new_hand,
   input  logic       hand_end,
   input  logic [1:0] raise,
   input  logic [1:0] accept,
   input  logic [1:0] reject,
   output logic [3:0] hand_value,
   output logic [3:0] pending_value,
   output logic       waiting,
   output logic       resp_player,
   output logic [1:0] last_raiser,
   output logic       in_hand,
   output logic       fold_valid,
   output logic       fold_winner,
   output logic       err,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      WAIT = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] hand_value_q, hand_value_d;
   logic [3:0] pending_value_q, pending_value_d;
   logic       waiting_q, waiting_d;
   logic       resp_player_q, resp_player_d;
   logic [1:0] last_raiser_q, last_raiser_d;
   logic       in_hand_q, in_hand_d;
   logic       fold_valid_q, fold_valid_d;
   logic       fold_winner_q, fold_winner_d;
   logic       err_q, err_d;

   logic       r;
   logic       r_raise, r_accept, r_reject, other_any;
   logic       open_raise_ok;

   function automatic logic [3:0] next_value(input logic [3:0] v);
      case (v)
         4'd1:    next_value = 4'd3;
         4'd3:    next_value = 4'd6;
         4'd6:    next_value = 4'd9;
         default: next_value = 4'd12;
      endcase
   endfunction

   always_comb begin
      state_d         = state_q;
      hand_value_d    = hand_value_q;
      pending_value_d = pending_value_q;
      waiting_d       = waiting_q;
      resp_player_d   = resp_player_q;
      last_raiser_d   = last_raiser_q;
      in_hand_d       = in_hand_q;
      fold_valid_d    = 1'b0;
      fold_winner_d   = fold_winner_q;
      err_d           = 1'b0;

      r         = resp_player_q;
      r_raise   = raise[r];
      r_accept  = accept[r];
      r_reject  = reject[r];
      other_any = raise[~r] | accept[~r] | reject[~r];
      // A raise is legal only as a single bit, from someone other than the last raiser, below 12.
      open_raise_ok = ((raise == 2'b01) || (raise == 2'b10)) &&
                      (raise != last_raiser_q) && (hand_value_q != 4'd12);

      if (new_hand) begin
         state_d         = OPEN;
         hand_value_d    = 4'd1;
         pending_value_d = 4'd0;
         waiting_d       = 1'b0;
         last_raiser_d   = 2'b00;
         in_hand_d       = 1'b1;
      end else begin
         case (state_q)
            OPEN: begin
               if (hand_end) begin
                  state_d   = IDLE;
                  in_hand_d = 1'b0;
               end else if ((|accept) || (|reject) || (raise == 2'b11)) begin
                  err_d = 1'b1;
               end else if (raise != 2'b00) begin
                  if (open_raise_ok) begin
                     state_d         = WAIT;
                     waiting_d       = 1'b1;
                     pending_value_d = next_value(hand_value_q);
                     resp_player_d   = ~raise[1];
                     last_raiser_d   = raise;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            WAIT: begin
               if (hand_end || other_any) begin
                  err_d = 1'b1;
               end else if (r_reject) begin
                  state_d         = IDLE;
                  waiting_d       = 1'b0;
                  in_hand_d       = 1'b0;
                  pending_value_d = 4'd0;
                  fold_valid_d    = 1'b1;
                  fold_winner_d   = ~r;
               end else if (r_raise) begin
                  // Re-raise implicitly accepts the outstanding offer first.
                  if (pending_value_q != 4'd12) begin
                     hand_value_d    = pending_value_q;
                     pending_value_d = next_value(pending_value_q);
                     resp_player_d   = ~r;
                     last_raiser_d   = r ? 2'b10 : 2'b01;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (r_accept) begin
                  state_d         = OPEN;
                  waiting_d       = 1'b0;
                  hand_value_d    = pending_value_q;
                  pending_value_d = 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q         <= IDLE;
         hand_value_q    <= 4'd0;
         pending_value_q <= 4'd0;
         waiting_q       <= 1'b0;
         resp_player_q   <= 1'b0;
         last_raiser_q   <= 2'b00;
         in_hand_q       <= 1'b0;
         fold_valid_q    <= 1'b0;
         fold_winner_q   <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         hand_value_q    <= hand_value_d;
         pending_value_q <= pending_value_d;
         waiting_q       <= waiting_d;
         resp_player_q   <= resp_player_d;
         last_raiser_q   <= last_raiser_d;
         in_hand_q       <= in_hand_d;
         fold_valid_q    <= fold_valid_d;
         fold_winner_q   <= fold_winner_d;
         err_q           <= err_d;
      end
   end

   assign hand_value    = hand_value_q;
   assign pending_value = pending_value_q;
   assign waiting       = waiting_q;
   assign resp_player   = resp_player_q;
   assign last_raiser   = last_raiser_q;
   assign in_hand       = in_hand_q;
   assign fold_valid    = fold_valid_q;
   assign fold_winner   = fold_winner_q;
   assign err           = err_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_truco_bet_ctrl.sv
// Directed bench for truco_bet_ctrl: each step pushes a hand-computed output vector,
// a monitor pops and compares it one edge later.
module tb_truco_bet_ctrl;

   localparam int W = 18;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OPEN = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       new_hand = 1'b0;
   logic       hand_end = 1'b0;
   logic [1:0] raise = 2'b00;
   logic [1:0] accept = 2'b00;
   logic [1:0] reject = 2'b00;
   logic [3:0] hand_value, pending_value;
   logic       waiting, resp_player, in_hand, fold_valid, fold_winner, err;
   logic [1:0] last_raiser, dbg_state;

   logic [W-1:0] exp_q[$];
   int           tag_q[$];
   int           n_checks = 0;
   int           n_pass = 0;
   int           step_no = 0;

   truco_bet_ctrl dut (
      .clk(clk), .clr(clr), .new_hand(new_hand), .hand_end(hand_end),
      .raise(raise), .accept(accept), .reject(reject),
      .hand_value(hand_value), .pending_value(pending_value), .waiting(waiting),
      .resp_player(resp_player), .last_raiser(last_raiser), .in_hand(in_hand),
      .fold_valid(fold_valid), .fold_winner(fold_winner), .err(err),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ev(input int hv, input int pv, input bit w, input bit rp,
                                       input logic [1:0] lr, input bit ih, input bit fv,
                                       input bit fw, input bit er, input logic [1:0] st);
      logic [3:0] h4, p4;
      h4 = hv[3:0];
      p4 = pv[3:0];
      return {h4, p4, w, rp, lr, ih, fv, fw, er, st};
   endfunction

   // Inputs change on the falling edge; the expected vector applies after the next rising edge.
   task automatic step(input bit c, input bit nh, input bit he, input logic [1:0] ra,
                       input logic [1:0] ac, input logic [1:0] rj, input logic [W-1:0] e);
      @(negedge clk);
      clr = c; new_hand = nh; hand_end = he; raise = ra; accept = ac; reject = rj;
      step_no++;
      exp_q.push_back(e);
      tag_q.push_back(step_no);
      @(posedge clk);
   endtask

   initial begin : monitor
      logic [W-1:0] got, e;
      int t;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            got = {hand_value, pending_value, waiting, resp_player, last_raiser,
                   in_hand, fold_valid, fold_winner, err, dbg_state};
            n_checks++;
            if (got === e) n_pass++;
            else $display("FAIL step%0d: got hv=%0d pv=%0d w=%b rp=%b lr=%b ih=%b fv=%b fw=%b err=%b st=%0d, exp hv=%0d pv=%0d w=%b rp=%b lr=%b ih=%b fv=%b fw=%b err=%b st=%0d",
                          t, got[17:14], got[13:10], got[9], got[8], got[7:6], got[5], got[4], got[3], got[2], got[1:0],
                          e[17:14], e[13:10], e[9], e[8], e[7:6], e[5], e[4], e[3], e[2], e[1:0]);
         end
      end
   end

   initial begin : driver
      int guard;
      // reset, reset overriding new_hand, idle ignores requests silently
      step(1, 0, 0, 2'b00, 2'b00, 2'b00, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, S_IDLE));
      step(1, 1, 0, 2'b01, 2'b00, 2'b00, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, S_IDLE));
      step(0, 0, 0, 2'b01, 2'b10, 2'b01, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, S_IDLE));
      // full ladder
      step(0, 1, 0, 2'b00, 2'b00, 2'b00, ev(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, S_OPEN));
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, ev(1, 3, 1, 1, 2'b01, 1, 0, 0, 0, S_WAIT));
      step(0, 0, 0, 2'b10, 2'b00, 2'b00, ev(3, 6, 1, 0, 2'b10, 1, 0, 0, 0, S_WAIT));
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, ev(6, 9, 1, 1, 2'b01, 1, 0, 0, 0, S_WAIT));
      step(0, 0, 0, 2'b10, 2'b00, 2'b00, ev(9, 12, 1, 0, 2'b10, 1, 0, 0, 0, S_WAIT));
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, ev(9, 12, 1, 0, 2'b10, 1, 0, 0, 1, S_WAIT));
      step(0, 0, 0, 2'b00, 2'b01, 2'b00, ev(12, 0, 0, 0, 2'b10, 1, 0, 0, 0, S_OPEN));
      step(0, 0, 0, 2'b10, 2'b00, 2'b00, ev(12, 0, 0, 0, 2'b10, 1, 0, 0, 1, S_OPEN));
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, ev(12, 0, 0, 0, 2'b10, 1, 0, 0, 1, S_OPEN));
      step(0, 0, 1, 2'b00, 2'b00, 2'b00, ev(12, 0, 0, 0, 2'b10, 0, 0, 0, 0, S_IDLE));
      // fold at value 3
      step(0, 1, 0, 2'b00, 2'b00, 2'b00, ev(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, S_OPEN));
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, ev(1, 3, 1, 1, 2'b01, 1, 0, 0, 0, S_WAIT));
      step(0, 0, 0, 2'b00, 2'b10, 2'b00, ev(3, 0, 0, 1, 2'b01, 1, 0, 0, 0, S_OPEN));
      step(0, 0, 0, 2'b10, 2'b00, 2'b00, ev(3, 6, 1, 0, 2'b10, 1, 0, 0, 0, S_WAIT));
      step(0, 0, 0, 2'b00, 2'b00, 2'b01, ev(3, 0, 0, 0, 2'b10, 0, 1, 1, 0, S_IDLE));
      step(0, 0, 0, 2'b00, 2'b00, 2'b00, ev(3, 0, 0, 0, 2'b10, 0, 0, 1, 0, S_IDLE));
      // illegal turns
      step(0, 1, 0, 2'b00, 2'b00, 2'b00, ev(1, 0, 0, 0, 2'b00, 1, 0, 1, 0, S_OPEN));
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, ev(1, 3, 1, 1, 2'b01, 1, 0, 1, 0, S_WAIT));
      step(0, 0, 0, 2'b00, 2'b01, 2'b00, ev(1, 3, 1, 1, 2'b01, 1, 0, 1, 1, S_WAIT));
      step(0, 0, 1, 2'b00, 2'b00, 2'b00, ev(1, 3, 1, 1, 2'b01, 1, 0, 1, 1, S_WAIT));
      step(0, 0, 0, 2'b00, 2'b10, 2'b00, ev(3, 0, 0, 1, 2'b01, 1, 0, 1, 0, S_OPEN));
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, ev(3, 0, 0, 1, 2'b01, 1, 0, 1, 1, S_OPEN));
      step(0, 0, 0, 2'b00, 2'b00, 2'b10, ev(3, 0, 0, 1, 2'b01, 1, 0, 1, 1, S_OPEN));
      step(0, 0, 0, 2'b10, 2'b00, 2'b00, ev(3, 6, 1, 0, 2'b10, 1, 0, 1, 0, S_WAIT));
      step(0, 0, 0, 2'b01, 2'b01, 2'b00, ev(6, 9, 1, 1, 2'b01, 1, 0, 1, 0, S_WAIT));
      // simultaneity: reject beats accept, double raise is an error
      step(0, 0, 0, 2'b00, 2'b10, 2'b10, ev(6, 0, 0, 1, 2'b01, 0, 1, 0, 0, S_IDLE));
      step(0, 1, 0, 2'b00, 2'b00, 2'b00, ev(1, 0, 0, 1, 2'b00, 1, 0, 0, 0, S_OPEN));
      step(0, 0, 0, 2'b11, 2'b00, 2'b00, ev(1, 0, 0, 1, 2'b00, 1, 0, 0, 1, S_OPEN));
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, ev(1, 3, 1, 1, 2'b01, 1, 0, 0, 0, S_WAIT));
      step(0, 0, 0, 2'b10, 2'b00, 2'b00, ev(3, 6, 1, 0, 2'b10, 1, 0, 0, 0, S_WAIT));
      // new_hand in WAIT wins over a same-cycle reject
      step(0, 1, 0, 2'b00, 2'b00, 2'b01, ev(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, S_OPEN));
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, ev(1, 3, 1, 1, 2'b01, 1, 0, 0, 0, S_WAIT));
      step(0, 0, 0, 2'b10, 2'b00, 2'b00, ev(3, 6, 1, 0, 2'b10, 1, 0, 0, 0, S_WAIT));
      // clr mid-WAIT with pending 6, overriding a same-cycle reject
      step(1, 0, 0, 2'b00, 2'b00, 2'b01, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, S_IDLE));
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, S_IDLE));
      @(negedge clk);
      clr = 0; new_hand = 0; hand_end = 0; raise = 0; accept = 0; reject = 0;
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
